// File: rtl/cr16_bram_arbiter.sv
// Two-requester round-robin arbiter sharing one synchronous-read BRAM port.
// Each access is issued for one cycle; reads add a capture cycle for the 1-cycle BRAM latency.
module cr16_bram_arbiter #(
   parameter int unsigned P_DATA_WIDTH    = 16,
   parameter int unsigned P_ADDRESS_WIDTH = 10
) (
   input  logic                       I_CLK,
   input  logic                       I_RESET,
   input  logic                       I_REQ_0,
   input  logic                       I_REQ_1,
   input  logic                       I_WE_0,
   input  logic                       I_WE_1,
   input  logic [P_ADDRESS_WIDTH-1:0] I_ADDR_0,
   input  logic [P_ADDRESS_WIDTH-1:0] I_ADDR_1,
   input  logic [P_DATA_WIDTH-1:0]    I_WDATA_0,
   input  logic [P_DATA_WIDTH-1:0]    I_WDATA_1,
   output logic                       O_GNT_0,
   output logic                       O_GNT_1,
   output logic                       O_RVALID_0,
   output logic                       O_RVALID_1,
   output logic [P_DATA_WIDTH-1:0]    O_RDATA_0,
   output logic [P_DATA_WIDTH-1:0]    O_RDATA_1,
   output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
   output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
   output logic                       O_BRAM_WRITE_ENABLE,
   input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA,
   output logic                       O_BUSY
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic                       prio_q, prio_d;
   logic                       win_q, win_d;
   logic                       we_q, we_d;
   logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [P_DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [P_DATA_WIDTH-1:0]    rdata_0_q, rdata_0_d;
   logic [P_DATA_WIDTH-1:0]    rdata_1_q, rdata_1_d;
   logic                       rvalid_0_q, rvalid_0_d;
   logic                       rvalid_1_q, rvalid_1_d;

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q    <= S_IDLE;
         prio_q     <= 1'b0;
         win_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_0_q  <= '0;
         rdata_1_q  <= '0;
         rvalid_0_q <= 1'b0;
         rvalid_1_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         win_q      <= win_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_0_q  <= rdata_0_d;
         rdata_1_q  <= rdata_1_d;
         rvalid_0_q <= rvalid_0_d;
         rvalid_1_q <= rvalid_1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      win_d      = win_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_0_d  = rdata_0_q;
      rdata_1_d  = rdata_1_q;
      rvalid_0_d = 1'b0;
      rvalid_1_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (I_REQ_0 || I_REQ_1) begin
               // Pointer only matters on a tie; a lone requester always wins.
               win_d   = (I_REQ_0 && I_REQ_1) ? prio_q : I_REQ_1;
               prio_d  = ~win_d;
               we_d    = win_d ? I_WE_1 : I_WE_0;
               addr_d  = win_d ? I_ADDR_1 : I_ADDR_0;
               wdata_d = win_d ? I_WDATA_1 : I_WDATA_0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = we_q ? S_IDLE : S_CAPTURE;
         end
         S_CAPTURE: begin
            if (win_q) begin
               rdata_1_d  = I_BRAM_DATA;
               rvalid_1_d = 1'b1;
            end else begin
               rdata_0_d  = I_BRAM_DATA;
               rvalid_0_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign O_GNT_0             = (state_q == S_ISSUE) && !win_q;
   assign O_GNT_1             = (state_q == S_ISSUE) && win_q;
   assign O_BRAM_WRITE_ENABLE = (state_q == S_ISSUE) && we_q;
   assign O_BRAM_ADDRESS      = addr_q;
   assign O_BRAM_DATA         = wdata_q;
   assign O_BUSY              = (state_q != S_IDLE);
   assign O_RVALID_0          = rvalid_0_q;
   assign O_RVALID_1          = rvalid_1_q;
   assign O_RDATA_0           = rdata_0_q;
   assign O_RDATA_1           = rdata_1_q;

endmodule

// File: tb/tb_cr16_bram_arbiter.sv
// Bench for cr16_bram_arbiter: directed scenarios plus random traffic against a
// cycle-scheduled transaction model and a behavioural BRAM.
module tb_cr16_bram_arbiter;

   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rv0, rv1, bwe, busy;
   logic [DW-1:0] rdata0, rdata1, bdata, bram_rdata;
   logic [AW-1:0] baddr;

   cr16_bram_arbiter #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) dut (
      .I_CLK(clk), .I_RESET(rst),
      .I_REQ_0(req0), .I_REQ_1(req1), .I_WE_0(we0), .I_WE_1(we1),
      .I_ADDR_0(addr0), .I_ADDR_1(addr1), .I_WDATA_0(wdata0), .I_WDATA_1(wdata1),
      .O_GNT_0(gnt0), .O_GNT_1(gnt1), .O_RVALID_0(rv0), .O_RVALID_1(rv1),
      .O_RDATA_0(rdata0), .O_RDATA_1(rdata1),
      .O_BRAM_ADDRESS(baddr), .O_BRAM_DATA(bdata), .O_BRAM_WRITE_ENABLE(bwe),
      .I_BRAM_DATA(bram_rdata), .O_BUSY(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural BRAM port B: synchronous read, one cycle latency.
   logic [DW-1:0] bram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bwe) bram[baddr] <= bdata;
      bram_rdata <= bram[baddr];
   end

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: each accepted access lays out its expected outputs in future cycle slots.
   typedef struct packed {
      logic          gnt0, gnt1, we, addr_v, data_v, rv0, rv1;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] rdata;
   } slot_t;

   slot_t         sched [8];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_r0, exp_r1;
   int            ptr, free_cyc, last_acc;

   always @(negedge clk) begin
      slot_t         sl;
      logic [2:0]    s0, s1, s2, s3;
      int            w;
      logic          mwe;
      logic [AW-1:0] ma;
      logic [DW-1:0] md;
      cyc++;
      s0 = 3'(cyc);
      if (rst) begin
         for (int i = 0; i < 8; i++) sched[i] = '0;
         ptr = 0; free_cyc = 0; last_acc = -10; exp_r0 = '0; exp_r1 = '0;
         chk("rst_gnt0", 32'(gnt0), 0);
         chk("rst_gnt1", 32'(gnt1), 0);
         chk("rst_we", 32'(bwe), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_rv0", 32'(rv0), 0);
         chk("rst_rv1", 32'(rv1), 0);
         chk("rst_addr", 32'(baddr), 0);
         chk("rst_data", 32'(bdata), 0);
         chk("rst_rdata0", 32'(rdata0), 0);
         chk("rst_rdata1", 32'(rdata1), 0);
      end else begin
         sl = sched[s0];
         if (sl.rv0) exp_r0 = sl.rdata;
         if (sl.rv1) exp_r1 = sl.rdata;
         if (sl.we) ref_mem[sl.addr] = sl.data;
         chk("gnt0", 32'(gnt0), 32'(sl.gnt0));
         chk("gnt1", 32'(gnt1), 32'(sl.gnt1));
         chk("bram_we", 32'(bwe), 32'(sl.we));
         chk("busy", 32'(busy), 32'((cyc > last_acc) && (cyc < free_cyc)));
         if (sl.addr_v) chk("bram_addr", 32'(baddr), 32'(sl.addr));
         if (sl.data_v) chk("bram_data", 32'(bdata), 32'(sl.data));
         chk("rvalid0", 32'(rv0), 32'(sl.rv0));
         chk("rvalid1", 32'(rv1), 32'(sl.rv1));
         chk("rdata0", 32'(rdata0), 32'(exp_r0));
         chk("rdata1", 32'(rdata1), 32'(exp_r1));
         sched[s0] = '0;
         if (cyc >= free_cyc && (req0 || req1)) begin
            w   = (req0 && req1) ? ptr : (req1 ? 1 : 0);
            ptr = (w == 0) ? 1 : 0;
            mwe = (w == 1) ? we1 : we0;
            ma  = (w == 1) ? addr1 : addr0;
            md  = (w == 1) ? wdata1 : wdata0;
            s1 = 3'(cyc + 1); s2 = 3'(cyc + 2); s3 = 3'(cyc + 3);
            sched[s1].gnt0   = (w == 0);
            sched[s1].gnt1   = (w == 1);
            sched[s1].we     = mwe;
            sched[s1].addr_v = 1'b1;
            sched[s1].addr   = ma;
            sched[s1].data_v = 1'b1;
            sched[s1].data   = md;
            if (!mwe) begin
               sched[s2].addr_v = 1'b1;
               sched[s2].addr   = ma;
               sched[s3].rv0    = (w == 0);
               sched[s3].rv1    = (w == 1);
               sched[s3].rdata  = ref_mem[ma];
            end
            last_acc = cyc;
            free_cyc = cyc + (mwe ? 2 : 3);
         end
      end
   end

   logic gnt_seen0, gnt_seen1;
   always @(negedge clk) begin
      gnt_seen0 <= gnt0;
      gnt_seen1 <= gnt1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_access(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
      we = 1'($urandom % 2);
      a  = AW'($urandom % 16);
      d  = DW'($urandom);
   endtask

   initial begin
      int            order [4];
      int            n;
      int            gcyc [3];
      int            pulses;
      int            rst_left;
      logic [DW-1:0] v;

      for (int i = 0; i < (1 << AW); i++) begin
         bram[i]    = '0;
         ref_mem[i] = '0;
      end
      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (3) step();
      chk("lit_reset_busy", 32'(busy), 0);
      chk("lit_reset_rdata0", 32'(rdata0), 0);
      rst = 1'b0;
      step();

      // Single write from requester 0.
      req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 16'hBEEF;
      step();
      chk("lit_wr_gnt0", 32'(gnt0), 1);
      chk("lit_wr_we", 32'(bwe), 1);
      chk("lit_wr_addr", 32'(baddr), 32'h005);
      chk("lit_wr_data", 32'(bdata), 32'hBEEF);
      req0 = 0;
      step();
      chk("lit_wr_done_busy", 32'(busy), 0);

      // Single read from requester 1.
      req1 = 1; we1 = 0; addr1 = 10'h005;
      step();
      chk("lit_rd_gnt1", 32'(gnt1), 1);
      req1 = 0;
      step();
      chk("lit_rd_cap_we", 32'(bwe), 0);
      chk("lit_rd_cap_addr", 32'(baddr), 32'h005);
      step();
      chk("lit_rd_rvalid1", 32'(rv1), 1);
      chk("lit_rd_rdata1", 32'(rdata1), 32'hBEEF);
      chk("lit_rd_rdata0", 32'(rdata0), 0);
      step();

      // Contention: both held across reset release.
      rst = 1;
      req0 = 1; req1 = 1; we0 = 1; we1 = 1;
      addr0 = 10'h010; addr1 = 10'h011; wdata0 = 16'h1111; wdata1 = 16'h2222;
      step(); step();
      rst = 0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("lit_cont_one_gnt", 32'(gnt0 && gnt1), 0);
         if ((gnt0 || gnt1) && n < 4) begin
            order[n] = gnt1 ? 1 : 0;
            n++;
         end
      end
      req0 = 0; req1 = 0;
      chk("lit_cont_count", 32'(n), 4);
      for (int i = 0; i < 4; i++) chk("lit_cont_order", 32'(order[i]), 32'(i % 2));
      step(); step();

      // Back-to-back writes from requester 0.
      req0 = 1; we0 = 1; addr0 = 10'h000; wdata0 = 16'hA000;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (gnt0 && n < 3) begin
            gcyc[n] = cyc;
            n++;
            if (n < 3) begin
               addr0  = AW'(n);
               wdata0 = 16'hA000 + DW'(n);
            end else begin
               req0 = 0;
            end
         end
      end
      req0 = 0;
      chk("lit_b2b_count", 32'(n), 3);
      chk("lit_b2b_space1", 32'(gcyc[1] - gcyc[0]), 2);
      chk("lit_b2b_space2", 32'(gcyc[2] - gcyc[1]), 2);
      for (int i = 0; i < 3; i++) begin
         v = 16'hA000 + DW'(i);
         chk("lit_b2b_bram", 32'(bram[i]), 32'(v));
      end

      // Reset pulsed during the capture cycle of a read.
      req0 = 1; we0 = 0; addr0 = 10'h005;
      step();
      chk("lit_rc_gnt0", 32'(gnt0), 1);
      req0 = 0;
      step();
      chk("lit_rc_busy", 32'(busy), 1);
      rst = 1;
      #1;
      chk("lit_rc_async_busy", 32'(busy), 0);
      chk("lit_rc_async_addr", 32'(baddr), 0);
      step();
      chk("lit_rc_no_rvalid", 32'(rv0), 0);
      step();
      rst = 0;
      req1 = 1; we1 = 0; addr1 = 10'h005;
      step();
      chk("lit_rc_next_gnt1", 32'(gnt1), 1);
      req1 = 0;
      step(); step();
      chk("lit_rc_next_rvalid1", 32'(rv1), 1);
      chk("lit_rc_next_rdata1", 32'(rdata1), 32'hBEEF);
      step();

      // Idle: nothing may happen.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (gnt0 || gnt1 || rv0 || rv1 || bwe || busy) pulses++;
      end
      chk("lit_idle_activity", 32'(pulses), 0);

      // Random traffic honouring the requester handshake, with occasional resets.
      rst_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst = 0;
         end else if (($urandom % 200) == 0) begin
            rst = 1;
            rst_left = 1 + int'($urandom % 2);
         end
         if (req0) begin
            if (gnt_seen0) begin
               if (($urandom % 2) == 0) rand_access(we0, addr0, wdata0);
               else req0 = 0;
            end
         end else if (($urandom % 3) == 0) begin
            req0 = 1;
            rand_access(we0, addr0, wdata0);
         end
         if (req1) begin
            if (gnt_seen1) begin
               if (($urandom % 2) == 0) rand_access(we1, addr1, wdata1);
               else req1 = 0;
            end
         end else if (($urandom % 3) == 0) begin
            req1 = 1;
            rand_access(we1, addr1, wdata1);
         end
         step();
      end
      rst = 0; req0 = 0; req1 = 0;
      repeat (5) step();

      for (int i = 0; i < 32; i++) chk("bram_contents", 32'(bram[i]), 32'(ref_mem[i]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cr16_bram_arbiter.md
CR16_BRAM_ARBITER -- requirements
Module: cr16_bram_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- P_DATA_WIDTH, 16, BRAM word width.
- P_ADDRESS_WIDTH, 10, BRAM word address width.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
- I_CLK  in  1  sole clock; all state updates on rising edge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_REQ_0 / I_REQ_1  in  1  access request from requester 0 / 1.
- I_WE_0 / I_WE_1  in  1  1 = write, 0 = read.
- I_ADDR_0 / I_ADDR_1  in  P_ADDRESS_WIDTH  word address.
- I_WDATA_0 / I_WDATA_1  in  P_DATA_WIDTH  write data.
- O_GNT_0 / O_GNT_1  out  1  one-cycle pulse: request accepted and issued.
- O_RVALID_0 / O_RVALID_1  out  1  one-cycle pulse: O_RDATA_x holds new read data.
- O_RDATA_0 / O_RDATA_1  out  P_DATA_WIDTH  read data, held until the next read completes for that requester.
- O_BRAM_ADDRESS  out  P_ADDRESS_WIDTH  to BRAM port B address.
- O_BRAM_DATA  out  P_DATA_WIDTH  to BRAM port B write data.
- O_BRAM_WRITE_ENABLE  out  1  to BRAM port B write enable.
- I_BRAM_DATA  in  P_DATA_WIDTH  from BRAM port B read data; synchronous read, 1-cycle latency.
- O_BUSY  out  1  high when state is not S_IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: S_IDLE, S_ISSUE and S_CAPTURE.
REQ-004 In S_IDLE with any I_REQ_x high, the block SHALL select a winner, latch that requester's WE/ADDR/WDATA and the winner ID, and go to S_ISSUE; with no request it SHALL stay in S_IDLE.
REQ-005 Winner selection SHALL be round-robin:
- Only one request high: that requester wins.
- Both high: the requester named by the priority pointer wins.
REQ-006 The priority pointer SHALL update to the non-winning requester on every transition to S_ISSUE.
REQ-007 In S_ISSUE, O_BRAM_ADDRESS and O_BRAM_DATA SHALL present the latched values.
REQ-008 In S_ISSUE, O_BRAM_WRITE_ENABLE SHALL equal the latched WE, and O_GNT of the winner SHALL be high for exactly this cycle.
REQ-009 From S_ISSUE, a write SHALL return to S_IDLE and a read SHALL go to S_CAPTURE.
REQ-010 In S_CAPTURE, O_BRAM_WRITE_ENABLE SHALL be 0 and O_BRAM_ADDRESS SHALL hold the latched address.
REQ-011 On the S_CAPTURE clock edge, I_BRAM_DATA SHALL be registered into O_RDATA of the winner, and the FSM SHALL return to S_IDLE.
REQ-012 O_RVALID of the winner SHALL be high for exactly the one cycle following S_CAPTURE.
REQ-013 Latency, with the request first sampled in cycle t:
- O_GNT in t+1.
- BRAM write committed at the end of t+1.
- O_RVALID in t+3.
REQ-014 Issue rate: at most one access is issued per 2 cycles (write) or 3 cycles (read).
REQ-015 Requester handshake: the requester SHALL hold REQ/WE/ADDR/WDATA stable until it sees O_GNT, and SHALL drop REQ on the following edge unless it has a new access.
REQ-016 A request still high in the S_IDLE cycle after its grant SHALL be treated as a new access.
REQ-017 Requests arriving while in S_ISSUE or S_CAPTURE SHALL be ignored until S_IDLE; they SHALL NOT be lost if held.
REQ-018 Outside S_ISSUE, O_BRAM_WRITE_ENABLE SHALL be 0, and at most one O_GNT_x and at most one O_RVALID_x SHALL be high in any cycle.
REQ-019 O_RDATA of the non-winning requester SHALL never change.

Reset
REQ-020 While I_RESET is high, asynchronously and independent of the clock:
- state = S_IDLE and priority pointer = 0.
- all O_GNT_x, O_RVALID_x, O_BRAM_WRITE_ENABLE and O_BUSY = 0.
- O_BRAM_ADDRESS, O_BRAM_DATA and all O_RDATA_x = 0.
REQ-021 Reset asserted mid-transaction (S_ISSUE or S_CAPTURE) SHALL abort it: no O_GNT or O_RVALID is produced for the aborted access, and no write occurs after reset assertion.
REQ-022 On the first edge after reset deassertion, the block SHALL evaluate requests as in S_IDLE.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single write: requester 0 writes 16'hBEEF to 10'h005; O_GNT_0 one cycle later with O_BRAM_WRITE_ENABLE=1, ADDRESS=10'h005, DATA=16'hBEEF.
- Single read: requester 1 then reads 10'h005; O_GNT_1 in t+1, O_RVALID_1 in t+3 with O_RDATA_1=16'hBEEF; O_RDATA_0 unchanged.
- Contention: both requesters raise REQ together and hold it after reset; grants alternate 0,1,0,1 across four accesses; never both O_GNT_x high.
- Back-to-back: requester 0 holds REQ high for three writes to 10'h000..10'h002; three O_GNT_0 pulses spaced 2 cycles apart; the BRAM holds all three values.
- Reset in S_CAPTURE: read issued, I_RESET pulsed during S_CAPTURE; no O_RVALID, all outputs 0 during reset, and the next request is serviced normally.
- Idle: no requests for 20 cycles; O_BUSY=0, O_BRAM_WRITE_ENABLE=0 and no GNT or RVALID pulses.
